// File: rtl/tmds_channel_encoder.sv
// TMDS channel encoder: 8b data / 2b control to 10b symbol, 2-cycle latency.
// Optional TERC4 data-island path is enabled by defining TMDS_TERC4_EN.
module tmds_channel_encoder #(
  parameter int         CNT_W     = 5,
  parameter logic [9:0] RST_TOKEN = 10'b1101010100
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
`ifdef TMDS_TERC4_EN
  input  logic       i_island,
  input  logic [3:0] i_aux,
`endif
  output logic [9:0] o_data,
  output logic       o_de
);

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [8:0] qm_d, qm_q;
  logic       de1_q;
  logic [1:0] ctrl1_q;
  logic [3:0] n1;
  logic       use_xnor;
  logic       acc;

  logic [9:0]       data_d, data_q;
  logic             de2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [3:0]       n1q, n0q;
  logic [CNT_W-1:0] diff;
  logic             cnt_pos, cnt_neg;
  logic             case_a, case_b;
  logic             is_data, sel_ctl, sel_a, sel_b;
  logic             sel_isl;

`ifdef TMDS_TERC4_EN
  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  logic       island1_q;
  logic [3:0] aux1_q;
  assign sel_isl = island1_q;
`else
  assign sel_isl = 1'b0;
`endif

  // Prefix parity gives the XOR chain; XNOR flips every odd bit.
  always_comb begin
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b0, i_data[i]};
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !i_data[0]);
    qm_d = '0;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ i_data[i];
      qm_d[i] = acc ^ (use_xnor & ((i % 2) == 1));
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      qm_q    <= '0;
      de1_q   <= 1'b0;
      ctrl1_q <= '0;
`ifdef TMDS_TERC4_EN
      island1_q <= 1'b0;
      aux1_q    <= '0;
`endif
    end else begin
      qm_q    <= qm_d;
      de1_q   <= i_de;
      ctrl1_q <= i_ctrl;
`ifdef TMDS_TERC4_EN
      island1_q <= i_island;
      aux1_q    <= i_aux;
`endif
    end
  end

  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b0, qm_q[i]};
    n0q = 4'd8 - n1q;
    diff = CNT_W'(n1q) - CNT_W'(n0q);
    cnt_neg = cnt_q[CNT_W-1];
    cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);
    case_a = (cnt_q == '0) || (n1q == n0q);
    case_b = (cnt_pos && n1q > n0q) || (cnt_neg && n0q > n1q);
    is_data = de1_q && !sel_isl;
    sel_ctl = !de1_q && !sel_isl;
    sel_a = is_data && case_a;
    sel_b = is_data && !case_a && case_b;
  end

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      sel_isl: begin
`ifdef TMDS_TERC4_EN
        data_d = TERC4[aux1_q];
`endif
        cnt_d = '0;
      end
      sel_ctl: begin
        unique case (ctrl1_q)
          2'b00: data_d = CTL_00;
          2'b01: data_d = CTL_01;
          2'b10: data_d = CTL_10;
          2'b11: data_d = CTL_11;
        endcase
        cnt_d = '0;
      end
      sel_a: begin
        data_d = {~qm_q[8], qm_q[8],
                  qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
      end
      sel_b: begin
        data_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + (qm_q[8] ? TWO : '0) - diff;
      end
      default: begin
        data_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - (qm_q[8] ? '0 : TWO) + diff;
      end
    endcase
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_q <= RST_TOKEN;
      de2_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      de2_q  <= de1_q;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data = data_q;
  assign o_de   = de2_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: vector table, scoreboard, random stream.
// Define TMDS_TERC4_EN to also exercise the TERC4 island path.
module tb_tmds_channel_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] ctrl = '0;
  logic [9:0] o_data;
  logic       o_de;
`ifdef TMDS_TERC4_EN
  logic       island = 1'b0;
  logic [3:0] aux = '0;
`endif

  always #5 clk = ~clk;

  tmds_channel_encoder dut (
    .i_pixclk (clk),
    .i_reset_n(rst_n),
    .i_de     (de),
    .i_data   (data),
    .i_ctrl   (ctrl),
`ifdef TMDS_TERC4_EN
    .i_island (island),
    .i_aux    (aux),
`endif
    .o_data   (o_data),
    .o_de     (o_de)
  );

  typedef struct {
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [9:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [9:0] d;
    logic       de;
    string      name;
  } exp_t;

  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  exp_t exp_q[$];
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;
  int   mcnt = 0;

  function automatic logic [9:0] model(logic isl, logic [3:0] ax,
                                       logic dv, logic [7:0] d,
                                       logic [1:0] c);
    logic [8:0] qm;
    logic       xn;
    int         n1, ones, zeros;
    if (isl) begin
      mcnt = 0;
      return TERC[ax];
    end
    if (!dv) begin
      mcnt = 0;
      case (c)
        2'b00: return 10'b1101010100;
        2'b01: return 10'b0010101011;
        2'b10: return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    ones = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (mcnt == 0 || ones == zeros) begin
      mcnt += qm[8] ? (ones - zeros) : (zeros - ones);
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end
    if ((mcnt > 0 && ones > zeros) || (mcnt < 0 && zeros > ones)) begin
      mcnt += 2 * int'(qm[8]) + zeros - ones;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    mcnt += -2 * int'(!qm[8]) + ones - zeros;
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic check(string name, logic [9:0] gd, logic gde,
                       logic [9:0] ed, logic ede);
    checks++;
    if (gd !== ed || gde !== ede) begin
      errors++;
      $display("FAIL %s: got o_data=%h o_de=%b, expected o_data=%h o_de=%b",
               name, gd, gde, ed, ede);
    end
  endtask

  // One pixel: check the symbol now at the output, then drive the next.
  task automatic cycle(logic isl, logic [3:0] ax, logic dv,
                       logic [7:0] d, logic [1:0] c,
                       logic use_tbl, logic [9:0] texp, string name);
    exp_t e;
    logic [9:0] m;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, o_data, o_de, e.d, e.de);
    end
    de = dv;
    data = d;
    ctrl = c;
`ifdef TMDS_TERC4_EN
    island = isl;
    aux = ax;
`endif
    m = model(isl, ax, dv, d, c);
    e.d = use_tbl ? texp : m;
    e.de = dv;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic release_reset();
    exp_t e;
    de = 1'b0;
    ctrl = 2'b00;
`ifdef TMDS_TERC4_EN
    island = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0;
    exp_q.delete();
    e.d = 10'h354;
    e.de = 1'b0;
    e.name = "post_reset";
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 2'b00, 10'h354, "ctl00"};
    tbl[1]  = '{1'b0, 8'h00, 2'b01, 10'h0AB, "ctl01"};
    tbl[2]  = '{1'b0, 8'h00, 2'b10, 10'h154, "ctl10"};
    tbl[3]  = '{1'b0, 8'h00, 2'b11, 10'h2AB, "ctl11"};
    tbl[4]  = '{1'b1, 8'h00, 2'b00, 10'h100, "zero_a"};
    tbl[5]  = '{1'b1, 8'h00, 2'b00, 10'h3FF, "zero_b"};
    tbl[6]  = '{1'b1, 8'h00, 2'b00, 10'h100, "zero_c"};
    tbl[7]  = '{1'b0, 8'h00, 2'b00, 10'h354, "ctl_clear"};
    tbl[8]  = '{1'b1, 8'hFF, 2'b00, 10'h200, "xnor_ff"};
    tbl[9]  = '{1'b1, 8'h00, 2'b00, 10'h3FF, "after_ff"};
    tbl[10] = '{1'b0, 8'h00, 2'b01, 10'h0AB, "ctl_mid"};
    tbl[11] = '{1'b1, 8'h00, 2'b00, 10'h100, "restart_a"};

    // Reset held: output pinned regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_hold", o_data, o_de, 10'h354, 1'b0);
      de = 1'($urandom);
      data = 8'($urandom);
      ctrl = 2'($urandom);
    end
    release_reset();

    for (int i = 0; i < 12; i++)
      cycle(1'b0, 4'h0, tbl[i].de, tbl[i].data, tbl[i].ctrl,
            1'b1, tbl[i].exp, tbl[i].name);

`ifdef TMDS_TERC4_EN
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 4'(i), 1'($urandom), 8'($urandom), 2'($urandom),
            1'b1, TERC[i], "terc4");
    cycle(1'b0, 4'h0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, "post_terc4");
`endif

    // Data burst then async reset mid-stream.
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 4'h0, 1'b1, 8'($urandom), 2'b00, 1'b0, '0, "burst");
    cycle(1'b0, 4'h0, 1'b1, 8'h00, 2'b00, 1'b0, '0, "burst_tail");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", o_data, o_de, 10'h354, 1'b0);
    @(negedge clk);
    check("reset_after_burst", o_data, o_de, 10'h354, 1'b0);
    release_reset();

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 19) == 0)
        cycle(1'b0, 4'h0, 1'b0, 8'($urandom), 2'($urandom),
              1'b0, '0, "rand_ctl");
      else
        cycle(1'b0, 4'h0, 1'b1, 8'($urandom), 2'($urandom),
              1'b0, '0, "rand_data");
    end
    cycle(1'b0, 4'h0, 1'b0, 8'h00, 2'b00, 1'b0, '0, "drain");
    cycle(1'b0, 4'h0, 1'b0, 8'h00, 2'b00, 1'b0, '0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Per-channel DVI/HDMI TMDS encoder: turns 8-bit pixel data or 2-bit control into one 10-bit TMDS symbol per pixel clock.
- Sits directly upstream of the 10:1 TMDS serializer; o_data feeds the serializer's 10-bit parallel input.
- One instance per colour channel (B, G, R).
- Two-stage pipeline: transition minimisation, then DC-balance with a running disparity counter.

Parameters:
- CNT_W, 5, width of the signed running-disparity counter (two's complement; must hold −8..+8 and intermediate sums).
- RST_TOKEN, 10'b1101010100, o_data value while in reset (control token for C=00).

Ports:
- i_pixclk  input  1  pixel clock; every register is in this domain.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_de  input  1  data enable: 1 = video data period, 0 = control period.
- i_data  input  8  pixel byte, sampled when i_de=1.
- i_ctrl  input  2  {C1,C0} control bits, sampled when i_de=0.
- o_data  output  10  TMDS symbol; bit 0 is serialized first.
- o_de  output  1  i_de delayed to align with o_data.

Behaviour:
- Reset (async assert, sync release to i_pixclk):
  - o_data=RST_TOKEN, o_de=0, disparity cnt=0, all pipeline registers cleared.
  - Reset asserted mid-stream discards in-flight symbols immediately.
- Latency: exactly 2 i_pixclk cycles from input to o_data/o_de. Throughput is 1 symbol per cycle with no stalls.
- Stage 1 (registered; q_m plus delayed de/ctrl):
  - n1 = popcount(i_data).
  - If n1>4, or n1==4 and i_data[0]==0: XNOR mode.
    - q_m[0]=D[0]; q_m[i]=q_m[i-1] XNOR D[i] for i=1..7; q_m[8]=0.
  - Else: XOR mode, same chain with XOR; q_m[8]=1.
- Stage 2 (registered output), with n1q/n0q = ones/zeros in q_m[7:0]:
  - Case A, cnt==0 or n1q==n0q:
    - o[9]=~q_m[8], o[8]=q_m[8], o[7:0]= q_m[8] ? q_m[7:0] : ~q_m[7:0].
    - cnt += q_m[8] ? (n1q−n0q) : (n0q−n1q).
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - o[9]=1, o[8]=q_m[8], o[7:0]=~q_m[7:0].
    - cnt += 2·q_m[8] + (n0q−n1q).
  - Case C, otherwise:
    - o[9]=0, o[8]=q_m[8], o[7:0]=q_m[7:0].
    - cnt += −2·(~q_m[8]) + (n1q−n0q).
- Control period (delayed de=0):
  - o_data by ctrl: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - cnt forced to 0.
- Boundaries:
  - de 1→0: the first control symbol appears 2 cycles later; cnt cleared on that symbol.
  - de 0→1: the first data symbol is encoded from cnt=0.
  - cnt never exceeds ±8 for legal operation; arithmetic is signed CNT_W-bit with no saturation.
  - i_data/i_ctrl are don't-care in the opposite period.

Optional Feature:
- Macro: TMDS_TERC4_EN.
- When defined:
  - Adds ports i_island (1) and i_aux (4).
  - When i_island=1 (priority over i_de), the channel emits the TERC4 code for i_aux, 2-cycle latency, cnt forced to 0.
  - TERC4 table 0..F: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
  - o_de remains the delayed i_de.
- When undefined: no extra ports and no TERC4 logic.

Test Plan:
- Reset: hold i_reset_n=0, toggle inputs → o_data=10'h354, o_de=0. Release → after 2 cycles, output follows input.
- Control: i_de=0, ctrl 00/01/10/11 on consecutive cycles → o_data 0x354, 0x0AB, 0x154, 0x2AB starting 2 cycles later.
- Data balance: i_de=1, i_data=0x00 ×3 from cnt=0 → o_data 0x100, 0x3FF, 0x100; cnt −8, +2, −6.
- XNOR path: cnt=0, i_data=0xFF → o_data 0x200, cnt=−8. The run-length of o_data bits over a random 1000-byte stream matches a reference model bit-exactly.
- Boundary: data burst then i_de=0 → cnt=0 on the first control symbol. Next data 0x00 → 0x100 (Case A, cnt=0). Async reset mid-burst → o_data=0x354 within the same cycle.
- TERC4 (macro on): i_island=1, i_aux=0..F → the 16 table codes in order, 2-cycle latency.
